// File: rtl/vga_timing_ctrl.sv
// VGA scan timing engine: programmable H/V counters, sync/blank decode, frame-boundary config apply.
// Optional config validation is compiled in with `define VGA_CFG_CHECK_EN.
module vga_timing_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned H_VIS_DEF = 640,
  parameter int unsigned H_SS_DEF  = 656,
  parameter int unsigned H_SE_DEF  = 752,
  parameter int unsigned H_TOT_DEF = 800,
  parameter int unsigned V_VIS_DEF = 480,
  parameter int unsigned V_SS_DEF  = 490,
  parameter int unsigned V_SE_DEF  = 492,
  parameter int unsigned V_TOT_DEF = 525,
  parameter bit          SYNC_ACT  = 1'b0
) (
  input  logic             clk_25MHz,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_h_vis,
  input  logic [CNT_W-1:0] cfg_h_ss,
  input  logic [CNT_W-1:0] cfg_h_se,
  input  logic [CNT_W-1:0] cfg_h_tot,
  input  logic [CNT_W-1:0] cfg_v_vis,
  input  logic [CNT_W-1:0] cfg_v_ss,
  input  logic [CNT_W-1:0] cfg_v_se,
  input  logic [CNT_W-1:0] cfg_v_tot,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start,
  output logic             cfg_pending,
  output logic             cfg_error
);

  typedef struct packed {
    logic [CNT_W-1:0] h_vis;
    logic [CNT_W-1:0] h_ss;
    logic [CNT_W-1:0] h_se;
    logic [CNT_W-1:0] h_tot;
    logic [CNT_W-1:0] v_vis;
    logic [CNT_W-1:0] v_ss;
    logic [CNT_W-1:0] v_se;
    logic [CNT_W-1:0] v_tot;
  } timing_t;

  typedef enum logic {
    SLOT_FREE,
    SLOT_PENDING
  } slot_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  localparam timing_t TIMING_DEF = '{
    h_vis: CNT_W'(H_VIS_DEF),
    h_ss:  CNT_W'(H_SS_DEF),
    h_se:  CNT_W'(H_SE_DEF),
    h_tot: CNT_W'(H_TOT_DEF),
    v_vis: CNT_W'(V_VIS_DEF),
    v_ss:  CNT_W'(V_SS_DEF),
    v_se:  CNT_W'(V_SE_DEF),
    v_tot: CNT_W'(V_TOT_DEF)
  };

  timing_t          act_q, act_d, shd_q, cfg_in;
  slot_t            state_q, state_d;
  logic [CNT_W-1:0] h_d, v_d;
  logic             h_last, v_last, apply, xfer, cfg_ok;
  logic             hs_d, vs_d, vo_d, ls_d, fs_d;

  assign cfg_in = '{
    h_vis: cfg_h_vis, h_ss: cfg_h_ss, h_se: cfg_h_se, h_tot: cfg_h_tot,
    v_vis: cfg_v_vis, v_ss: cfg_v_ss, v_se: cfg_v_se, v_tot: cfg_v_tot
  };

`ifdef VGA_CFG_CHECK_EN
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  function automatic logic axis_ok(input logic [CNT_W-1:0] vis, ss, se, tot);
    return (vis < ss) && (ss < se) && (se <= tot) && (tot >= TWO);
  endfunction

  assign cfg_ok = axis_ok(cfg_h_vis, cfg_h_ss, cfg_h_se, cfg_h_tot) &&
                  axis_ok(cfg_v_vis, cfg_v_ss, cfg_v_se, cfg_v_tot);

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      cfg_error <= 1'b0;
    end else if (xfer && !cfg_ok) begin
      cfg_error <= 1'b1;
    end
  end
`else
  assign cfg_ok    = 1'b1;
  assign cfg_error = 1'b0;
`endif

  assign xfer   = cfg_valid && cfg_ready;
  assign h_last = (h_count == act_q.h_tot - ONE);
  assign v_last = (v_count == act_q.v_tot - ONE);
  assign apply  = enable && h_last && v_last && (state_q == SLOT_PENDING);

  // Decode is taken from the next counts and next active timing, so the
  // registered syncs/strobes line up with the registered counts.
  always_comb begin
    state_d = state_q;
    act_d   = apply ? shd_q : act_q;
    h_d     = h_count;
    v_d     = v_count;

    if (enable) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_count + ONE;
      end else begin
        h_d = h_count + ONE;
      end
    end

    unique case (state_q)
      SLOT_FREE:    if (xfer && cfg_ok) state_d = SLOT_PENDING;
      SLOT_PENDING: if (apply)          state_d = SLOT_FREE;
      default:                          state_d = SLOT_FREE;
    endcase

    hs_d = ((h_d >= act_d.h_ss) && (h_d < act_d.h_se)) ? SYNC_ACT : ~SYNC_ACT;
    vs_d = ((v_d >= act_d.v_ss) && (v_d < act_d.v_se)) ? SYNC_ACT : ~SYNC_ACT;
    vo_d = (h_d < act_d.h_vis) && (v_d < act_d.v_vis);
    ls_d = enable && (h_d == '0);
    fs_d = ls_d && (v_d == '0);
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      h_count     <= '0;
      v_count     <= '0;
      act_q       <= TIMING_DEF;
      shd_q       <= TIMING_DEF;
      state_q     <= SLOT_FREE;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      cfg_ready   <= 1'b1;
      cfg_pending <= 1'b0;
    end else begin
      h_count     <= h_d;
      v_count     <= v_d;
      act_q       <= act_d;
      state_q     <= state_d;
      hsync       <= hs_d;
      vsync       <= vs_d;
      video_on    <= vo_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
      cfg_ready   <= (state_d == SLOT_FREE);
      cfg_pending <= (state_d == SLOT_PENDING);
      if (xfer && cfg_ok) shd_q <= cfg_in;
    end
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the VGA scan, replacing the free-running horizontal and vertical counters with one controlled timing engine.
- Generates the H/V counts, the sync pulses, video_on and line/frame strobes for the pixel pipeline.
- Timing is programmable through a valid/ready config port. A new mode is shadowed and applied only at a frame boundary, so no frame is ever torn.

Parameters:
- CNT_W, 16, width of all count/config fields
- H_VIS_DEF, 640, reset horizontal visible pixels
- H_SS_DEF, 656, reset hsync start count
- H_SE_DEF, 752, reset hsync end count (exclusive)
- H_TOT_DEF, 800, reset horizontal total
- V_VIS_DEF, 480, reset visible lines
- V_SS_DEF, 490, reset vsync start line
- V_SE_DEF, 492, reset vsync end line (exclusive)
- V_TOT_DEF, 525, reset vertical total
- SYNC_ACT, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk_25MHz  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  advance scan when 1; freeze all state when 0
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config slot free
- cfg_h_vis, cfg_h_ss, cfg_h_se, cfg_h_tot  in  CNT_W each  horizontal timing
- cfg_v_vis, cfg_v_ss, cfg_v_se, cfg_v_tot  in  CNT_W each  vertical timing
- h_count  out  CNT_W  current pixel column, 0..h_tot-1
- v_count  out  CNT_W  current line, 0..v_tot-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  h_count<h_vis and v_count<v_vis
- line_start  out  1  one-cycle pulse when h_count==0
- frame_start  out  1  one-cycle pulse when h_count==0 and v_count==0
- cfg_pending  out  1  a shadowed config awaits frame boundary
- cfg_error  out  1  sticky invalid-config flag (optional feature only; else tied 0)

Behaviour:
- Reset (async assert, sync release):
  - h_count=v_count=0; active registers loaded with *_DEF values.
  - hsync=vsync=~SYNC_ACT; video_on=1; line_start=frame_start=0.
  - cfg_ready=1; cfg_pending=0; cfg_error=0.
- All outputs are registered. Decode is computed from next-state counts, so hsync/vsync/video_on/strobes are aligned with h_count/v_count in the same cycle (zero relative latency).
- Scan, on each enabled cycle:
  - If h_count==h_tot-1: h_count<=0, and v_count advances (wraps to 0 if v_count==v_tot-1).
  - Otherwise: h_count+1.
  - Default wrap is 799 -> 0 and line 524 -> 0.
- enable=0: counts, syncs and video_on hold; line_start/frame_start forced 0; config handshake still operates.
- hsync is active iff h_ss<=h_count<h_se; vsync is active iff v_ss<=v_count<v_se. Comparisons are unsigned CNT_W.
- Config handshake:
  - Transfer occurs on cfg_valid&&cfg_ready; the 8 fields are captured into the shadow, cfg_pending<=1, cfg_ready<=0.
  - cfg_valid may drop without a transfer; no state changes.
- Apply:
  - When pending and the scan wraps from (h_tot-1, v_tot-1) to (0,0) on an enabled cycle, shadow->active, cfg_pending<=0, cfg_ready<=1 the next cycle.
  - The new frame's first cycle already uses the new timing for its decode.
- Simultaneous events:
  - A frame wrap in the same cycle as a transfer does not apply that new config; it waits one full frame.
  - A transfer while cfg_ready=0 is impossible by rule (ready low).
- Active-register change while counts exceed the new totals is impossible, because apply happens only at (0,0).
- Reset mid-frame or mid-pending discards the shadow and restores the defaults.

Optional Feature:
- VGA_CFG_CHECK_EN defined:
  - On transfer, the config is validated: vis<ss<se<=tot and tot>=2 for both axes.
  - Invalid: not shadowed, cfg_ready stays 1, cfg_error<=1 (sticky until rst).
- Undefined: no check; every transfer is accepted; cfg_error tied 0.

Test Plan:
- Reset default run, 2 full frames:
  - h_count wraps 799->0; v_count wraps 524->0.
  - hsync low for exactly h_count 656..751; vsync low for lines 490..491.
  - video_on is high for 640x480 per frame; frame_start period is 420000 cycles.
- Config mid-frame at line 100 with h(320,328,376,400), v(240,245,247,262):
  - cfg_ready drops and cfg_pending=1 until (0,0).
  - Next frame period is 104800 cycles; hsync is active on 328..375.
- Config accepted in the wrap cycle from (799,524): the current frame stays at the old timing; the new timing takes effect only after the following frame wraps.
- enable toggled 0 for 50 cycles at h_count=700: counts/syncs freeze; no line_start; scan resumes at 701.
- rst asserted mid-frame with cfg_pending=1: all outputs return to reset values asynchronously; next frame uses the 800x525 defaults.
- With VGA_CFG_CHECK_EN, offer h_ss=700 > h_se=600: no transfer, cfg_error=1, timing unchanged; a subsequent valid config is still accepted.
